// File: rtl/food_spawner.sv
// food_spawner: picks a free board cell for the next food item.
// Random picks come from the rng stage and are checked against the occupancy
// memory. After MAX_TRIES failed picks the search falls back to a linear scan
// of the whole board, starting just after the last candidate.
module food_spawner #(
  parameter int unsigned BOARD_WIDTH  = 40,
  parameter int unsigned BOARD_HEIGHT = 30,
  parameter int unsigned MAX_TRIES    = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       spawn_req,
  input  logic       food_clear,
  input  logic [5:0] rand_x,
  input  logic [4:0] rand_y,
  output logic       occ_rd_en,
  output logic [5:0] occ_x,
  output logic [4:0] occ_y,
  input  logic       occ_data,
  output logic [5:0] food_x,
  output logic [4:0] food_y,
  output logic       food_valid,
  output logic       busy,
  output logic       done,
  output logic       board_full
);

  localparam int unsigned XW = 6;
  localparam int unsigned YW = 5;
  localparam int unsigned TW = 8;
  localparam int unsigned SW = 11;
  localparam int unsigned CELLS = BOARD_WIDTH * BOARD_HEIGHT;

  localparam logic [XW:0]   X_LIM    = (XW+1)'(BOARD_WIDTH);
  localparam logic [YW:0]   Y_LIM    = (YW+1)'(BOARD_HEIGHT);
  localparam logic [XW-1:0] X_LAST   = XW'(BOARD_WIDTH - 1);
  localparam logic [YW-1:0] Y_LAST   = YW'(BOARD_HEIGHT - 1);
  localparam logic [TW:0]   TRY_LIM  = (TW+1)'(MAX_TRIES);
  localparam logic [SW:0]   CELL_LIM = (SW+1)'(CELLS);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_READ,
    S_WAIT,
    S_SCAN
  } state_e;

  state_e          state_q, state_d;
  logic [XW-1:0]   cand_x_q, cand_x_d;
  logic [YW-1:0]   cand_y_q, cand_y_d;
  logic [TW-1:0]   tries_q, tries_d;
  logic [SW-1:0]   scan_cnt_q, scan_cnt_d;
  logic            scan_q, scan_d;
  logic [XW-1:0]   food_x_q, food_x_d;
  logic [YW-1:0]   food_y_q, food_y_d;
  logic            food_valid_q, food_valid_d;
  logic            done_q, done_d;
  logic            board_full_q, board_full_d;
  logic            occ_rd_en_q, occ_rd_en_d;
  logic            busy_q, busy_d;
  logic            cand_in_range;

  assign cand_in_range = ({1'b0, cand_x_q} < X_LIM) && ({1'b0, cand_y_q} < Y_LIM);

  // Next-state and registered-output logic for the search.
  always_comb begin
    state_d      = state_q;
    cand_x_d     = cand_x_q;
    cand_y_d     = cand_y_q;
    tries_d      = tries_q;
    scan_cnt_d   = scan_cnt_q;
    scan_d       = scan_q;
    food_x_d     = food_x_q;
    food_y_d     = food_y_q;
    food_valid_d = food_valid_q & ~food_clear;
    done_d       = 1'b0;
    board_full_d = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (spawn_req) begin
          tries_d    = '0;
          scan_cnt_d = '0;
          scan_d     = 1'b0;
          state_d    = S_ISSUE;
        end
      end
      S_ISSUE: begin
        cand_x_d = rand_x;
        cand_y_d = rand_y;
        state_d  = S_READ;
      end
      S_READ: begin
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (cand_in_range && !occ_data) begin
          food_x_d     = cand_x_q;
          food_y_d     = cand_y_q;
          food_valid_d = 1'b1;
          done_d       = 1'b1;
          state_d      = S_IDLE;
        end else if (!scan_q) begin
          if (({1'b0, tries_q} + (TW+1)'(1)) < TRY_LIM) begin
            tries_d = tries_q + TW'(1);
            state_d = S_ISSUE;
          end else begin
            scan_d  = 1'b1;
            state_d = S_SCAN;
            // Parking on the last cell makes the scan step land on (0,0).
            if (!cand_in_range) begin
              cand_x_d = X_LAST;
              cand_y_d = Y_LAST;
            end
          end
        end else if (({1'b0, scan_cnt_q} + (SW+1)'(1)) == CELL_LIM) begin
          board_full_d = 1'b1;
          state_d      = S_IDLE;
        end else begin
          scan_cnt_d = scan_cnt_q + SW'(1);
          state_d    = S_SCAN;
        end
      end
      S_SCAN: begin
        if (cand_x_q == X_LAST) begin
          cand_x_d = '0;
          cand_y_d = (cand_y_q == Y_LAST) ? '0 : cand_y_q + YW'(1);
        end else begin
          cand_x_d = cand_x_q + XW'(1);
        end
        state_d = S_READ;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    occ_rd_en_d = (state_d == S_READ);
    busy_d      = (state_d != S_IDLE);
  end

  // State and output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      cand_x_q     <= '0;
      cand_y_q     <= '0;
      tries_q      <= '0;
      scan_cnt_q   <= '0;
      scan_q       <= 1'b0;
      food_x_q     <= '0;
      food_y_q     <= '0;
      food_valid_q <= 1'b0;
      done_q       <= 1'b0;
      board_full_q <= 1'b0;
      occ_rd_en_q  <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      cand_x_q     <= cand_x_d;
      cand_y_q     <= cand_y_d;
      tries_q      <= tries_d;
      scan_cnt_q   <= scan_cnt_d;
      scan_q       <= scan_d;
      food_x_q     <= food_x_d;
      food_y_q     <= food_y_d;
      food_valid_q <= food_valid_d;
      done_q       <= done_d;
      board_full_q <= board_full_d;
      occ_rd_en_q  <= occ_rd_en_d;
      busy_q       <= busy_d;
    end
  end

  assign occ_rd_en  = occ_rd_en_q;
  assign occ_x      = cand_x_q;
  assign occ_y      = cand_y_q;
  assign food_x     = food_x_q;
  assign food_y     = food_y_q;
  assign food_valid = food_valid_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign board_full = board_full_q;

endmodule

// File: doc/food_spawner.md
Name: food_spawner

Overview:
- Downstream consumer of the LFSR random-coordinate generator.
- On request, picks a board cell for the next food item: samples rand_x/rand_y, checks the cell against the snake occupancy memory, and retries on collision.
- After MAX_TRIES failed random picks, falls back to a linear scan from the last candidate.
- Publishes food_x/food_y/food_valid to the game logic and renderer; flags board_full when no free cell exists.

Parameters:
- BOARD_WIDTH, 40, board columns; legal range 1..64.
- BOARD_HEIGHT, 30, board rows; legal range 1..32.
- MAX_TRIES, 16, random attempts before linear scan; legal range 1..255.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- spawn_req  in  1  single-cycle request to place new food.
- food_clear  in  1  food eaten; clears food_valid.
- rand_x  in  6  random column from the rng stage.
- rand_y  in  5  random row from the rng stage.
- occ_rd_en  out  1  occupancy read strobe.
- occ_x  out  6  occupancy read column.
- occ_y  out  5  occupancy read row.
- occ_data  in  1  1 = cell occupied; valid exactly 1 cycle after occ_rd_en.
- food_x  out  6  current food column.
- food_y  out  5  current food row.
- food_valid  out  1  food_x/food_y hold a placed item.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse when food is placed.
- board_full  out  1  one-cycle pulse when no free cell is found.

Behaviour:
- Reset (async, any state): state=IDLE; food_x=0, food_y=0, cand=0, counters=0; food_valid, done, board_full, occ_rd_en, busy all 0.
- Reset asserted mid-search abandons the search; no done or board_full is emitted.
- States:
  - IDLE
  - ISSUE: latch cand_x<=rand_x, cand_y<=rand_y.
  - READ: occ_rd_en=1, occ_x/occ_y=cand.
  - WAIT: evaluate occ_data.
  - SCAN: advance cand linearly.
- Transitions:
  - IDLE -> ISSUE on spawn_req; clear tries and scan_cnt.
  - ISSUE -> READ.
  - READ -> WAIT.
- WAIT, cell free (occ_data=0 and cand in range):
  - Register food_x/y<=cand, food_valid<=1, done pulse; -> IDLE.
- WAIT, cell blocked (occ_data=1, or cand out of range):
  - Random phase, tries+1 < MAX_TRIES: tries++; -> ISSUE.
  - Random phase, tries+1 == MAX_TRIES: enter scan phase; -> SCAN.
  - Scan phase, scan_cnt+1 == BOARD_WIDTH*BOARD_HEIGHT: board_full pulse, food_valid stays 0; -> IDLE.
  - Scan phase otherwise: scan_cnt++; -> SCAN.
- Out-of-range candidate (rand_x >= BOARD_WIDTH or rand_y >= BOARD_HEIGHT):
  - Treated as occupied and costs one try.
  - READ is still issued with occ_rd_en=1; occ_data is ignored.
  - Entering scan from an out-of-range candidate resets cand to (0,0) instead of incrementing.
- SCAN increment:
  - cand_x+1; at cand_x == BOARD_WIDTH-1, wrap cand_x to 0 and cand_y+1.
  - At cand_y == BOARD_HEIGHT-1 with cand_x wrapping, cand_y wraps to 0.
  - SCAN -> READ.
- scan_cnt is 11 bits; tries is 8 bits.
- Latency, free first pick: spawn_req high at edge N -> occ_rd_en high cycle N+2 -> done and food_valid high cycle N+4.
  - Each failed random try adds 3 cycles.
  - Each scan step adds 3 cycles.
- spawn_req while busy is ignored (not queued).
- food_clear clears food_valid in any state.
- food_clear and spawn_req in the same IDLE cycle: food_valid<=0 and the search starts.
- food_clear in the same cycle as the WAIT success: the new placement wins, so food_valid=1.
- food_x/food_y change only on a successful placement; they hold their value after food_clear.
- rand_x/rand_y are sampled only in ISSUE.

Test Plan:
- Empty board, rand=(17,9), spawn_req at cycle 10 -> occ_rd_en at 12 with occ=(17,9); done and food_valid at 14; food=(17,9); busy low at 14.
- occ_data=1 for the first two reads, rand sequence (3,4),(5,6),(7,8) -> three reads; food=(7,8); done at spawn+10.
- MAX_TRIES=4, all four random picks occupied, last pick (39,5), cell (0,6) free -> scan reads (0,6); food=(0,6); no board_full.
- rand_x=45 on the first try, then (2,2) free -> first read ignored as invalid; food=(2,2); tries counted as 1.
- All cells occupied, 40x30 board, MAX_TRIES=16 -> board_full pulses once after 16+1200 reads; food_valid=0; done never pulses.
- Reset asserted during WAIT -> all outputs 0 immediately (asynchronous); a subsequent spawn_req restarts cleanly. Also: spawn_req during busy is ignored; food_clear at the success cycle leaves food_valid=1.
